// File: rtl/ctx_update_ctrl.sv
// ---------------------------------------------------------------------------
// ctx_update_ctrl
//
// Read-modify-write sequencer for the JPEG-LS context store. It owns the
// context RAM ports and feeds the (external, combinational) bias-cancellation
// datapath that computes the updated A/B/C/N/Nn fields.
//
// After reset it sweeps every context with the initial word
// {A_INIT, 0, 0, 1, 0}. Once the sweep is done it accepts one update request
// per cycle. Each request goes through two stages:
//   stage 0 (accept cycle)   : RAM read issued
//   stage 1 (next cycle)     : word unpacked to dp_*, result written back
//
// Handshake: a request transfers on a cycle where req_valid && req_ready are
// both high. req_ready never depends on req_valid. A request held with
// req_valid high keeps its payload stable until it transfers.
//
// Configuration macro: CTX_FORWARD_EN
//   defined   : a one-cycle forward register resolves back-to-back updates of
//               the same context, so there are no stalls.
//   undefined : no forward register. req_ready drops for one cycle when the
//               incoming context equals the one in stage 1, so the read
//               happens after the write has committed.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start_init            re-run the init sweep (RUN state, stage 1 empty)
//   init_busy             high while the init sweep is running
//   req_*                 update request (valid/ready)
//   ram_rd_* / ram_wr_*   context RAM ports (read data returns next cycle,
//                         read-during-write returns old data)
//   dp_*                  current context and controls to the datapath
//   dp_*_new              datapath results
//   upd_done / upd_ctx    one pulse per retired request, with its context
// ---------------------------------------------------------------------------
module ctx_update_ctrl #(
  parameter int CTX_COUNT          = 367,
  parameter int CTX_ADDR_W         = 9,
  parameter int A_length           = 14,
  parameter int B_length           = 8,
  parameter int C_length           = 8,
  parameter int N_length           = 7,
  parameter int Nn_length          = 7,
  parameter int mode_length        = 2,
  parameter int modresidual_length = 8,
  parameter int RESET_THRESH       = 64,
  parameter int A_INIT             = 4,
  parameter int CTX_W              = 44
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_init,
  output logic                          init_busy,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CTX_ADDR_W-1:0]         req_ctx,
  input  logic [mode_length-1:0]        req_mode,
  input  logic [modresidual_length-1:0] req_err,
  input  logic                          req_ritype,
  output logic                          ram_rd_en,
  output logic [CTX_ADDR_W-1:0]         ram_rd_addr,
  input  logic [CTX_W-1:0]              ram_rd_data,
  output logic                          ram_wr_en,
  output logic [CTX_ADDR_W-1:0]         ram_wr_addr,
  output logic [CTX_W-1:0]              ram_wr_data,
  output logic [A_length-1:0]           dp_A,
  output logic [B_length-1:0]           dp_B,
  output logic [C_length-1:0]           dp_C,
  output logic [N_length-1:0]           dp_N,
  output logic [Nn_length-1:0]          dp_Nn,
  output logic                          dp_resetFlag,
  output logic [mode_length-1:0]        dp_mode,
  output logic [modresidual_length-1:0] dp_errValue,
  output logic                          dp_RIType,
  input  logic [A_length-1:0]           dp_A_new,
  input  logic [B_length-1:0]           dp_B_new,
  input  logic [C_length-1:0]           dp_C_new,
  input  logic [N_length-1:0]           dp_N_new,
  input  logic [Nn_length-1:0]          dp_Nn_new,
  output logic                          upd_done,
  output logic [CTX_ADDR_W-1:0]         upd_ctx
);

  // Packed word layout, MSB first: {A, B, C, N, Nn}
  localparam int NN_LSB = 0;
  localparam int N_LSB  = NN_LSB + Nn_length;
  localparam int C_LSB  = N_LSB + N_length;
  localparam int B_LSB  = C_LSB + C_length;
  localparam int A_LSB  = B_LSB + B_length;

  localparam logic [CTX_W-1:0] INIT_WORD = {A_length'(A_INIT), B_length'(0),
                                            C_length'(0), N_length'(1),
                                            Nn_length'(0)};
  localparam logic [CTX_ADDR_W-1:0]  LAST_CTX   = CTX_ADDR_W'(CTX_COUNT - 1);
  localparam logic [mode_length-1:0] MODE_REG   = mode_length'(0);
  localparam logic [mode_length-1:0] MODE_RI    = mode_length'(2);
  localparam logic [N_length-1:0]    N_THRESH   = N_length'(RESET_THRESH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [CTX_ADDR_W-1:0]           init_cnt_q, init_cnt_d;

  logic                            s1_valid_q, s1_valid_d;
  logic [CTX_ADDR_W-1:0]           s1_ctx_q, s1_ctx_d;
  logic [mode_length-1:0]          s1_mode_q, s1_mode_d;
  logic [modresidual_length-1:0]   s1_err_q, s1_err_d;
  logic                            s1_ritype_q, s1_ritype_d;

  logic                            start_init_take;
  logic                            hazard_stall;
  logic                            accept;
  logic                            init_wr;
  logic                            s1_writes;
  logic [CTX_W-1:0]                ctx_word;
  logic [CTX_W-1:0]                new_word;

`ifdef CTX_FORWARD_EN
  logic                            fwd_valid_q, fwd_valid_d;
  logic [CTX_ADDR_W-1:0]           fwd_ctx_q, fwd_ctx_d;
  logic [CTX_W-1:0]                fwd_word_q, fwd_word_d;
`endif

  // ---------------------------------------------------------------------
  // Control FSM: INIT sweep / RUN
  // ---------------------------------------------------------------------
  // start_init is only taken with stage 1 empty; the request port is closed
  // on that cycle so nothing enters stage 1 while the sweep owns the RAM.
  assign start_init_take = (state_q == ST_RUN) && start_init && !s1_valid_q;

`ifdef CTX_FORWARD_EN
  assign hazard_stall = 1'b0;
`else
  assign hazard_stall = s1_valid_q && (req_ctx == s1_ctx_q);
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_wr    = 1'b0;
    req_ready  = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        if (init_cnt_q == LAST_CTX) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        req_ready = !start_init_take && !hazard_stall;
        if (start_init_take) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // Combinational outputs must read 0 while reset is held, so the state
  // decode is qualified with reset here.
  assign init_busy = (state_q == ST_INIT) && !reset;

  // ---------------------------------------------------------------------
  // Stage 0: accept and issue the read
  // ---------------------------------------------------------------------
  assign accept      = req_valid && req_ready;
  assign ram_rd_en   = accept;
  assign ram_rd_addr = accept ? req_ctx : '0;

  always_comb begin
    s1_valid_d  = accept;
    s1_ctx_d    = s1_ctx_q;
    s1_mode_d   = s1_mode_q;
    s1_err_d    = s1_err_q;
    s1_ritype_d = s1_ritype_q;
    if (accept) begin
      s1_ctx_d    = req_ctx;
      s1_mode_d   = req_mode;
      s1_err_d    = req_err;
      s1_ritype_d = req_ritype;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: select word, drive datapath, write back
  // ---------------------------------------------------------------------
  always_comb begin
    ctx_word = ram_rd_data;
`ifdef CTX_FORWARD_EN
    // The RAM returns stale data when this read overlapped last cycle's
    // write to the same context; the forward register holds the fresh word.
    if (fwd_valid_q && (fwd_ctx_q == s1_ctx_q)) begin
      ctx_word = fwd_word_q;
    end
`endif
  end

  always_comb begin
    dp_A         = '0;
    dp_B         = '0;
    dp_C         = '0;
    dp_N         = '0;
    dp_Nn        = '0;
    dp_resetFlag = 1'b0;
    dp_mode      = '0;
    dp_errValue  = '0;
    dp_RIType    = 1'b0;
    if (s1_valid_q) begin
      dp_A         = ctx_word[A_LSB  +: A_length];
      dp_B         = ctx_word[B_LSB  +: B_length];
      dp_C         = ctx_word[C_LSB  +: C_length];
      dp_N         = ctx_word[N_LSB  +: N_length];
      dp_Nn        = ctx_word[NN_LSB +: Nn_length];
      dp_resetFlag = (ctx_word[N_LSB +: N_length] == N_THRESH);
      dp_mode      = s1_mode_q;
      dp_errValue  = s1_err_q;
      dp_RIType    = s1_ritype_q;
    end
  end

  assign new_word  = {dp_A_new, dp_B_new, dp_C_new, dp_N_new, dp_Nn_new};
  // Modes 1 and 3 are no-ops: they retire without touching the RAM.
  assign s1_writes = s1_valid_q && ((s1_mode_q == MODE_REG) || (s1_mode_q == MODE_RI));

  // The sweep and stage 1 never overlap: INIT is only entered with stage 1
  // empty and no request is accepted while in INIT.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (!reset) begin
      if (init_wr) begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = init_cnt_q;
        ram_wr_data = INIT_WORD;
      end else if (s1_writes) begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = s1_ctx_q;
        ram_wr_data = new_word;
      end
    end
  end

  assign upd_done = s1_valid_q;
  assign upd_ctx  = s1_valid_q ? s1_ctx_q : '0;

`ifdef CTX_FORWARD_EN
  // Holds the last write-back for exactly one cycle.
  always_comb begin
    fwd_valid_d = s1_writes;
    fwd_ctx_d   = fwd_ctx_q;
    fwd_word_d  = fwd_word_q;
    if (s1_writes) begin
      fwd_ctx_d  = s1_ctx_q;
      fwd_word_d = new_word;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_ctx_q    <= '0;
      s1_mode_q   <= '0;
      s1_err_q    <= '0;
      s1_ritype_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_ctx_q    <= s1_ctx_d;
      s1_mode_q   <= s1_mode_d;
      s1_err_q    <= s1_err_d;
      s1_ritype_q <= s1_ritype_d;
    end
  end

`ifdef CTX_FORWARD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_ctx_q   <= '0;
      fwd_word_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_ctx_q   <= fwd_ctx_d;
      fwd_word_q  <= fwd_word_d;
    end
  end
`endif

endmodule
